// File: rtl/uart_pkg.sv
// Shared UART definitions: TX read-FSM states and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD
  } txrd_state_t;

  localparam int unsigned UART_FRAME_BITS  = 10;
  localparam int unsigned UART_DEFAULT_DIV = 434;

endpackage

// File: rtl/ram128B.sv
// 128x8 single-port synchronous RAM; read data register only updates on a read enable.
module ram128B (
  input  logic       clk,
  input  logic       we,
  input  logic       re,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [128];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: start bit, 8 data bits LSB first, stop bit; each bit CLK_DIV cycles.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_DEFAULT_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       last_cycle,
  output logic       tx
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  assign last_cycle = busy && (bit_cnt == 4'(UART_FRAME_BITS - 1))
                           && (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      tx      <= 1'b1;
      bit_cnt <= '0;
      div_cnt <= '0;
      shreg   <= '1;
    end else if (load) begin
      shreg   <= {1'b1, data};
      tx      <= 1'b0;
      busy    <= 1'b1;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (busy) begin
      if (div_cnt == DW'(CLK_DIV - 1)) begin
        div_cnt <= '0;
        if (bit_cnt == 4'(UART_FRAME_BITS - 1)) begin
          busy <= 1'b0;
          tx   <= 1'b1;
        end else begin
          // The stop bit falls out of the shift register after the eight data bits.
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART TX path: 128-byte circular buffer in ram128B drained by an 8N1 serializer.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned UART_CLK_DIV = UART_DEFAULT_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [7:0] i_wdata,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_count,
  output logic       o_busy,
  output logic       o_tx
);

  txrd_state_t state;
  logic [6:0]  wp, rp;
  logic [7:0]  count;
  logic [7:0]  rdata;
  logic        push, pop, ser_ready, ser_last;

  assign o_full  = (count == 8'd128);
  assign o_empty = (count == 8'd0);
  assign o_count = count;

  assign push      = i_we && !o_full;
  assign ser_ready = !o_busy || ser_last;
  assign pop       = (state == LOAD) && ser_ready;

  ram128B u_ram (
    .clk   (clk),
    .we    (push),
    .re    ((state == FETCH) && !i_we),
    .addr  (i_we ? wp : rp),
    .wdata (i_wdata),
    .rdata (rdata)
  );

  uart_tx_serializer #(.CLK_DIV(UART_CLK_DIV)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (pop),
    .data       (rdata),
    .busy       (o_busy),
    .last_cycle (ser_last),
    .tx         (o_tx)
  );

  // The next byte is prefetched as soon as one is buffered and parked in LOAD
  // until the serializer's final stop-bit cycle, so frames abut with no idle gap.
  // The RAM read register only updates on a FETCH read, so writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 7'd1;
      if (pop)  rp <= rp + 7'd1;
      count <= count + {7'd0, push} - {7'd0, pop};
      case (state)
        IDLE:    if (count != 8'd0) state <= FETCH;
        FETCH:   if (!i_we) state <= LOAD;
        LOAD:    if (ser_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered with a 4-cycle bit period.
module tb_uart_tx_buffered;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, i_we;
  logic [7:0] i_wdata;
  logic       o_full, o_empty, o_busy, o_tx;
  logic [7:0] o_count;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  uart_tx_buffered #(.UART_CLK_DIV(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_we    (i_we),
    .i_wdata (i_wdata),
    .o_full  (o_full),
    .o_empty (o_empty),
    .o_count (o_count),
    .o_busy  (o_busy),
    .o_tx    (o_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Line receiver: decodes frames from o_tx into {stop, data}, with start-bit cycle stamps.
  logic [8:0]  rx_q [$];
  int unsigned rx_t [$];
  bit          rx_act = 1'b0;
  int          rx_cnt;
  logic [7:0]  rx_sh;
  logic        rx_stop;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (o_tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % D) == D / 2 && rx_cnt / D >= 1 && rx_cnt / D <= 8)
        rx_sh = {o_tx, rx_sh[7:1]};
      if (rx_cnt == 9 * D + D / 2) rx_stop = o_tx;
      if (rx_cnt == 10 * D - 1) begin
        rx_act = 1'b0;
        rx_q.push_back({rx_stop, rx_sh});
      end
    end
  end

  task automatic push(input logic [7:0] b);
    i_we = 1'b1;
    i_wdata = b;
    @(negedge clk);
    i_we = 1'b0;
  endtask

  task automatic wait_idle;
    int t;
    for (t = 0; t < 20000 && !(o_empty === 1'b1 && o_busy === 1'b0); t++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (t >= 20000) begin
      errors++;
      $display("FAIL wait_idle: empty=%b busy=%b, required empty=1 busy=0 within 20000 cycles", o_empty, o_busy);
    end
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic wait_rx(input int n, input int limit, input string name);
    int t;
    for (t = 0; t < limit && rx_q.size() < n; t++) @(negedge clk);
    repeat (2 * D) @(negedge clk);
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL %s_frames: got %0d frames, required %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_we = 1'b0; i_wdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (o_tx !== 1'b1)     begin errors++; $display("FAIL reset_tx: got %b required 1", o_tx); end
    checks++; if (o_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    checks++; if (o_full !== 1'b0)   begin errors++; $display("FAIL reset_full: got %b required 0", o_full); end
    checks++; if (o_empty !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b required 1", o_empty); end
    checks++; if (o_count !== 8'd0)  begin errors++; $display("FAIL reset_count: got %0d required 0", o_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [9:0] frame;
    int cur;
    frame = {1'b1, 8'h55, 1'b0};
    wait_idle();
    push(8'h55);
    checks++; if (o_count !== 8'd1) begin errors++; $display("FAIL single_count_k: got %0d required 1", o_count); end
    checks++; if (o_tx !== 1'b1)    begin errors++; $display("FAIL single_tx_k: got %b required 1", o_tx); end
    repeat (2) @(negedge clk);
    checks++; if (o_tx !== 1'b1)    begin errors++; $display("FAIL single_tx_k2: got %b required 1", o_tx); end
    @(negedge clk);
    checks++; if (o_tx !== 1'b0)    begin errors++; $display("FAIL single_start_k3: got %b required 0", o_tx); end
    checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL single_busy_k3: got %b required 1", o_busy); end
    checks++; if (o_count !== 8'd0) begin errors++; $display("FAIL single_count_k3: got %0d required 0", o_count); end
    cur = 3;
    for (int b = 1; b < 10; b++) begin
      repeat (5 + 4 * b - cur) @(negedge clk);
      cur = 5 + 4 * b;
      checks++;
      if (o_tx !== frame[b]) begin
        errors++; $display("FAIL single_bit%0d: got %b required %b", b, o_tx, frame[b]);
      end
    end
    repeat (42 - cur) @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b required 1", o_busy); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b required 0", o_busy); end
    checks++; if (o_tx !== 1'b1)   begin errors++; $display("FAIL single_tx_end: got %b required 1", o_tx); end
  endtask

  // Continuous pushes hold the read FSM in FETCH, so 128 bytes fill the buffer and 0x80/0x81 drop.
  task automatic test_full;
    wait_idle();
    for (int i = 0; i < 130; i++) begin
      i_we = 1'b1;
      i_wdata = 8'(i);
      @(negedge clk);
      if (i == 126) begin
        checks++; if (o_full !== 1'b0 || o_count !== 8'd127) begin
          errors++; $display("FAIL full_127: full=%b count=%0d required full=0 count=127", o_full, o_count); end
      end
      if (i == 127) begin
        checks++; if (o_full !== 1'b1 || o_count !== 8'd128) begin
          errors++; $display("FAIL full_128: full=%b count=%0d required full=1 count=128", o_full, o_count); end
      end
    end
    i_we = 1'b0;
    checks++; if (o_full !== 1'b1 || o_count !== 8'd128) begin
      errors++; $display("FAIL full_after_drop: full=%b count=%0d required full=1 count=128", o_full, o_count); end
    wait_rx(128, 128 * 10 * D + 500, "full");
    repeat (20 * D) @(negedge clk);
    checks++; if (rx_q.size() != 128) begin
      errors++; $display("FAIL full_no_extra: got %0d frames required 128", rx_q.size()); end
    for (int i = 0; i < 128 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== {1'b1, 8'(i)}) begin
        errors++; $display("FAIL full_byte%0d: got %h required %h", i, rx_q[i], {1'b1, 8'(i)});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
    wait_idle();
    for (int j = 0; j < 3; j++) begin
      i_we = 1'b1; i_wdata = exp[j]; @(negedge clk);
    end
    i_we = 1'b0;
    wait_rx(3, 300, "b2b");
    for (int j = 0; j < 3 && j < rx_q.size(); j++) begin
      checks++;
      if (rx_q[j] !== {1'b1, exp[j]}) begin
        errors++; $display("FAIL b2b_byte%0d: got %h required %h", j, rx_q[j], {1'b1, exp[j]});
      end
    end
    for (int j = 1; j < 3 && j < rx_t.size(); j++) begin
      checks++;
      if (rx_t[j] - rx_t[j-1] != 10 * D) begin
        errors++; $display("FAIL b2b_period%0d: got %0d cycles required %0d", j, rx_t[j] - rx_t[j-1], 10 * D);
      end
    end
  endtask

  task automatic test_fetch_stall;
    wait_idle();
    push(8'h11);
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      i_we = 1'b1; i_wdata = 8'h20 + 8'(j); @(negedge clk);
    end
    i_we = 1'b0;
    checks++; if (o_count !== 8'd6) begin errors++; $display("FAIL stall_count_k6: got %0d required 6", o_count); end
    @(negedge clk);
    checks++; if (o_tx !== 1'b1)    begin errors++; $display("FAIL stall_tx_k7: got %b required 1", o_tx); end
    @(negedge clk);
    checks++; if (o_tx !== 1'b0)    begin errors++; $display("FAIL stall_start_k8: got %b required 0", o_tx); end
    checks++; if (o_count !== 8'd5) begin errors++; $display("FAIL stall_count_k8: got %0d required 5", o_count); end
    wait_rx(6, 6 * 10 * D + 200, "stall");
    for (int j = 0; j < 6 && j < rx_q.size(); j++) begin
      logic [7:0] e;
      e = (j == 0) ? 8'h11 : 8'h20 + 8'(j - 1);
      checks++;
      if (rx_q[j] !== {1'b1, e}) begin
        errors++; $display("FAIL stall_byte%0d: got %h required %h", j, rx_q[j], {1'b1, e});
      end
    end
  endtask

  task automatic test_stream;
    logic [8:0] exp_q [$];
    logic [7:0] b;
    int t;
    wait_idle();
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (t = 0; t < 1000 && o_full === 1'b1; t++) @(negedge clk);
      if (t >= 1000) begin
        checks++; errors++;
        $display("FAIL stream_full_stuck: full=%b required 0 within 1000 cycles", o_full);
      end
      b = 8'(i * 37 + 5);
      push(b);
      exp_q.push_back({1'b1, b});
    end
    wait_rx(300, 300 * 10 * D + 1000, "stream");
    for (int i = 0; i < 300 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stream_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit saw_low;
    wait_idle();
    push(8'h3C);
    repeat (3) @(negedge clk);
    checks++; if (o_tx !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b required 0", o_tx); end
    for (int j = 0; j < 10; j++) begin
      i_we = 1'b1; i_wdata = 8'h40 + 8'(j); @(negedge clk);
    end
    i_we = 1'b0;
    checks++; if (o_count !== 8'd10) begin errors++; $display("FAIL rstmid_count_pre: got %0d required 10", o_count); end
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_tx !== 1'b1)     begin errors++; $display("FAIL rstmid_tx: got %b required 1", o_tx); end
    checks++; if (o_count !== 8'd0)  begin errors++; $display("FAIL rstmid_count: got %0d required 0", o_count); end
    checks++; if (o_empty !== 1'b1)  begin errors++; $display("FAIL rstmid_empty: got %b required 1", o_empty); end
    checks++; if (o_busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy: got %b required 0", o_busy); end
    rst = 1'b0;
    saw_low = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (o_tx !== 1'b1) saw_low = 1'b1;
    end
    checks++; if (saw_low)           begin errors++; $display("FAIL rstmid_quiet: tx went low=%b required 0", saw_low); end
    checks++; if (rx_q.size() != 0)  begin errors++; $display("FAIL rstmid_frames: got %0d required 0", rx_q.size()); end
    checks++; if (o_empty !== 1'b1)  begin errors++; $display("FAIL rstmid_empty_after: got %b required 1", o_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_fetch_stall();
    test_stream();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
